// File: rtl/alu_pkg.sv
// Shared constants and operand types for the operand-fetch stage and the ALU bit-slice array.
package alu_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] r2;
        logic [WIDTH_DEF-1:0] r3;
    } operand_pair_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one write port; entry 0 reads as zero.
module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b
);

    localparam int NREG = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Address 0 is forced to zero on read so the array entry itself never matters.
    assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file read, one-entry output register with valid/ready handshake.
// Optional macro RF_BYPASS_EN forwards same-cycle write data into an accepted read.
module operand_fetch
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rs3_addr,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [WIDTH-1:0]  r2,
    output logic [WIDTH-1:0]  r3
);

    logic [WIDTH-1:0] rf_r2;
    logic [WIDTH-1:0] rf_r3;
    logic [WIDTH-1:0] next_r2;
    logic [WIDTH-1:0] next_r3;
    logic             accept;

    regfile_2r1w #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rs2_addr),
        .rd_data_a (rf_r2),
        .rd_addr_b (rs3_addr),
        .rd_data_b (rf_r3)
    );

    // The output register frees up in the same cycle it is consumed.
    assign req_ready = !op_valid || op_ready;
    assign accept    = req_valid && req_ready;

`ifdef RF_BYPASS_EN
    logic wr_live;
    assign wr_live = wr_en && (wr_addr != '0);

    always_comb begin
        next_r2 = rf_r2;
        next_r3 = rf_r3;
        if (wr_live && (wr_addr == rs2_addr)) begin
            next_r2 = wr_data;
        end
        if (wr_live && (wr_addr == rs3_addr)) begin
            next_r3 = wr_data;
        end
    end
`else
    assign next_r2 = rf_r2;
    assign next_r3 = rf_r3;
`endif

    // r2/r3 only load on accept, so a stalled pair is a snapshot unaffected by later writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid <= 1'b0;
            r2       <= '0;
            r3       <= '0;
        end else if (accept) begin
            op_valid <= 1'b1;
            r2       <= next_r2;
            r3       <= next_r3;
        end else if (op_ready) begin
            op_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch (handshake, zero register, stall snapshot, reset).
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  rs2_addr;
    logic [4:0]  rs3_addr;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] r2;
    logic [31:0] r3;

    int n_cmp;
    int n_err;

    operand_fetch #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs2_addr  (rs2_addr),
        .rs3_addr  (rs3_addr),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .r2        (r2),
        .r3        (r3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        req_valid;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic        op_ready;
        logic        exp_rr;
        logic        exp_ov;
        logic        chk_data;
        logic [31:0] exp_r2;
        logic [31:0] exp_r3;
    } vec_t;

`ifdef RF_BYPASS_EN
    localparam logic [31:0] EXP_SAME_CYC_R2 = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_SAME_CYC_R3 = 32'hBEEF_0001;
`else
    localparam logic [31:0] EXP_SAME_CYC_R2 = 32'h0000_0011;
    localparam logic [31:0] EXP_SAME_CYC_R3 = 32'h0000_FFFF;
`endif

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                                logic rv, logic [4:0] a2, logic [4:0] a3, logic ordy,
                                logic err, logic eov, logic cd,
                                logic [31:0] e2, logic [31:0] e3);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
        v.req_valid = rv; v.rs2 = a2; v.rs3 = a3; v.op_ready = ordy;
        v.exp_rr = err; v.exp_ov = eov; v.chk_data = cd;
        v.exp_r2 = e2; v.exp_r3 = e3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; rs2_addr = '0; rs3_addr = '0; op_ready = 1'b0;

        //           we  wa  wd             rv  a2  a3  ordy rr ov cd r2              r3
        vecs[0]  = mk(0,  0, 32'h0,          1,  0,  0,  1,   1, 1, 1, 32'h0,          32'h0);
        vecs[1]  = mk(1,  5, 32'hA5A5_0F0F,  0,  0,  0,  1,   1, 0, 1, 32'h0,          32'h0);
        vecs[2]  = mk(1,  9, 32'h0000_FFFF,  0,  0,  0,  1,   1, 0, 0, 32'h0,          32'h0);
        vecs[3]  = mk(0,  0, 32'h0,          1,  5,  9,  1,   1, 1, 1, 32'hA5A5_0F0F,  32'h0000_FFFF);
        vecs[4]  = mk(0,  0, 32'h0,          1,  9,  5,  1,   1, 1, 1, 32'h0000_FFFF,  32'hA5A5_0F0F);
        vecs[5]  = mk(0,  0, 32'h0,          1,  5,  5,  1,   1, 1, 1, 32'hA5A5_0F0F,  32'hA5A5_0F0F);
        vecs[6]  = mk(1,  0, 32'hFFFF_FFFF,  0,  0,  0,  1,   1, 0, 0, 32'h0,          32'h0);
        vecs[7]  = mk(0,  0, 32'h0,          1,  0,  0,  1,   1, 1, 1, 32'h0,          32'h0);
        vecs[8]  = mk(1,  7, 32'h0000_0011,  0,  0,  0,  1,   1, 0, 0, 32'h0,          32'h0);
        vecs[9]  = mk(1,  7, 32'hDEAD_BEEF,  1,  7,  9,  1,   1, 1, 1, EXP_SAME_CYC_R2, 32'h0000_FFFF);
        vecs[10] = mk(0,  0, 32'h0,          1,  7,  7,  1,   1, 1, 1, 32'hDEAD_BEEF,  32'hDEAD_BEEF);
        vecs[11] = mk(0,  0, 32'h0,          1,  5,  9,  1,   1, 1, 1, 32'hA5A5_0F0F,  32'h0000_FFFF);
        vecs[12] = mk(1,  5, 32'h0000_1234,  1,  9,  9,  0,   0, 1, 1, 32'hA5A5_0F0F,  32'h0000_FFFF);
        vecs[13] = mk(0,  0, 32'h0,          1,  9,  9,  0,   0, 1, 1, 32'hA5A5_0F0F,  32'h0000_FFFF);
        vecs[14] = mk(0,  0, 32'h0,          1,  9,  9,  0,   0, 1, 1, 32'hA5A5_0F0F,  32'h0000_FFFF);
        vecs[15] = mk(0,  0, 32'h0,          0,  0,  0,  1,   1, 0, 1, 32'hA5A5_0F0F,  32'h0000_FFFF);
        vecs[16] = mk(0,  0, 32'h0,          1,  5,  9,  1,   1, 1, 1, 32'h0000_1234,  32'h0000_FFFF);
        vecs[17] = mk(1,  0, 32'h0000_CAFE,  1,  0,  0,  1,   1, 1, 1, 32'h0,          32'h0);
        vecs[18] = mk(1,  9, 32'hBEEF_0001,  1,  5,  9,  1,   1, 1, 1, 32'h0000_1234,  EXP_SAME_CYC_R3);

        // Reset held across an edge, then released mid-cycle so the next edge can accept.
        @(posedge clk);
        #1;
        chk("reset_op_valid", {31'b0, op_valid}, 32'd0);
        chk("reset_r2", r2, 32'd0);
        chk("reset_r3", r3, 32'd0);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("release_req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            wr_en     = vecs[i].wr_en;
            wr_addr   = vecs[i].wr_addr;
            wr_data   = vecs[i].wr_data;
            req_valid = vecs[i].req_valid;
            rs2_addr  = vecs[i].rs2;
            rs3_addr  = vecs[i].rs3;
            op_ready  = vecs[i].op_ready;
            #1;
            chk($sformatf("v%0d_req_ready", i), {31'b0, req_ready}, {31'b0, vecs[i].exp_rr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_op_valid", i), {31'b0, op_valid}, {31'b0, vecs[i].exp_ov});
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_r2", i), r2, vecs[i].exp_r2);
                chk($sformatf("v%0d_r3", i), r3, vecs[i].exp_r3);
            end
        end

        // Stall with a valid pair, then assert reset mid-cycle: outputs must clear without a clock edge.
        @(negedge clk);
        wr_en = 1'b0; req_valid = 1'b0; op_ready = 1'b0;
        #1;
        chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("stall_op_valid", {31'b0, op_valid}, 32'd1);
        chk("stall_r3", r3, EXP_SAME_CYC_R3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_op_valid", {31'b0, op_valid}, 32'd0);
        chk("async_rst_r2", r2, 32'd0);
        chk("async_rst_r3", r3, 32'd0);
        chk("async_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; rs2_addr = 5'd5; rs3_addr = 5'd9; op_ready = 1'b1;
        #1;
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("post_rst_op_valid", {31'b0, op_valid}, 32'd1);
        chk("post_rst_r2", r2, 32'd0);
        chk("post_rst_r3", r3, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
